// File: rtl/mem_issue_arbiter_pkg.sv
// Shared types and widths for the memory-issue arbiter.
package mem_issue_arbiter_pkg;

  localparam int WARP_ID_W = 3;
  localparam int BACKOFF_W = 5;
  localparam int OUTST_W   = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_issue_arbiter_rr_picker8.sv
// Combinational 8-way round-robin picker: first set request at or after ptr_i.
module rr_picker8
  import mem_issue_arbiter_pkg::*;
(
  input  logic [7:0]           req_i,
  input  logic [WARP_ID_W-1:0] ptr_i,
  output logic [7:0]           onehot_o,
  output logic [WARP_ID_W-1:0] enc_o,
  output logic                 valid_o
);

  // Scan from the farthest offset down so the nearest request to ptr_i wins.
  always_comb begin
    logic [WARP_ID_W-1:0] idx;
    onehot_o = '0;
    enc_o    = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr_i + WARP_ID_W'(i);
      if (req_i[idx]) begin
        onehot_o      = '0;
        onehot_o[idx] = 1'b1;
        enc_o         = idx;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_issue_arbiter.sv
// Memory-issue arbiter: round-robin grant of one warp per cycle into the MEM
// pipe, with an in-flight limit, per-warp replay back-off and a drain handshake.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
// NUM_WARPS must not exceed 8 (the picker is 8 wide).
module mem_issue_arbiter
  import mem_issue_arbiter_pkg::*;
#(
  parameter int NUM_WARPS       = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int BLOCK_CYCLES    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WARPS-1:0] req_valid_i,
  output logic [NUM_WARPS-1:0] grant_o,
  output logic                 grant_valid_o,
  output logic [WARP_ID_W-1:0] grant_warpID_o,
  input  logic                 neg_fb_valid_i,
  input  logic [WARP_ID_W-1:0] neg_fb_warpID_i,
  input  logic                 pos_fb_valid_i,
  input  logic [WARP_ID_W-1:0] pos_fb_warpID_i,
  input  logic                 drain_req_i,
  output logic                 drain_done_o,
  output logic [OUTST_W-1:0]   outstanding_o,
  output logic [NUM_WARPS-1:0] blocked_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]          perf_grant_cnt_o,
  output logic [31:0]          perf_stall_cnt_o
`endif
);

  localparam logic [OUTST_W-1:0]   MAX_OUT_C = OUTST_W'(MAX_OUTSTANDING);
  localparam logic [BACKOFF_W-1:0] BLOCK_C   = BACKOFF_W'(BLOCK_CYCLES);

  arb_state_e             state_q, state_d;
  logic [NUM_WARPS-1:0]   grant_q, grant_d;
  logic                   gvalid_q, gvalid_d;
  logic [WARP_ID_W-1:0]   gid_q, gid_d;
  logic [WARP_ID_W-1:0]   ptr_q, ptr_d;
  logic [OUTST_W-1:0]     out_q, out_d;
  logic                   done_q, done_d;
  logic [BACKOFF_W-1:0]   backoff_q [NUM_WARPS];
  logic [BACKOFF_W-1:0]   backoff_d [NUM_WARPS];

  logic                   issue_ok;
  logic [NUM_WARPS-1:0]   elig;
  logic [7:0]             elig_pad;
  logic [7:0]             pick_onehot;
  logic [WARP_ID_W-1:0]   pick_enc;
  logic                   pick_valid;

  // A warp granted last cycle is masked so its still-high request is not re-granted.
  assign issue_ok = (state_q == ST_RUN) && (out_q < MAX_OUT_C);
  assign elig     = req_valid_i & ~blocked_o & ~grant_q & {NUM_WARPS{issue_ok}};

  // Widen the eligible vector to the fixed 8-bit picker.
  always_comb begin
    elig_pad                = '0;
    elig_pad[NUM_WARPS-1:0] = elig;
  end

  rr_picker8 u_picker (
    .req_i    (elig_pad),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .enc_o    (pick_enc),
    .valid_o  (pick_valid)
  );

  // Per-warp back-off: negative feedback (re)loads, otherwise count down to zero.
  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_backoff
    assign blocked_o[gi] = |backoff_q[gi];

    // Reload wins over decrement, so repeated misses never accumulate.
    always_comb begin
      if (neg_fb_valid_i && (neg_fb_warpID_i == WARP_ID_W'(gi))) begin
        backoff_d[gi] = BLOCK_C;
      end else if (backoff_q[gi] != '0) begin
        backoff_d[gi] = backoff_q[gi] - 1'b1;
      end else begin
        backoff_d[gi] = '0;
      end
    end
  end

  // Grant registers and the round-robin pointer (pointer holds the next start warp).
  always_comb begin
    grant_d  = pick_onehot[NUM_WARPS-1:0];
    gvalid_d = pick_valid;
    gid_d    = pick_valid ? pick_enc : '0;
    ptr_d    = pick_valid ? pick_enc + 1'b1 : ptr_q;
  end

  // In-flight count: grant adds, each feedback subtracts, clamped to [0, MAX].
  always_comb begin
    int sum;
    sum = int'(out_q) + int'(pick_valid) - int'(pos_fb_valid_i) - int'(neg_fb_valid_i);
    if (sum < 0) begin
      out_d = '0;
    end else if (sum > MAX_OUTSTANDING) begin
      out_d = MAX_OUT_C;
    end else begin
      out_d = OUTST_W'(sum);
    end
  end

  // Drain FSM: a completion pulse fires once on entering DONE, which then stays
  // quiet until the drain request is withdrawn.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (drain_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((out_q == '0) && !gvalid_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!drain_req_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers; reset discards in-flight count, back-offs and pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      grant_q  <= '0;
      gvalid_q <= 1'b0;
      gid_q    <= '0;
      ptr_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < NUM_WARPS; i++) backoff_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gvalid_q <= gvalid_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
      out_q    <= out_d;
      done_q   <= done_d;
      for (int i = 0; i < NUM_WARPS; i++) backoff_q[i] <= backoff_d[i];
    end
  end

  assign grant_o        = grant_q;
  assign grant_valid_o  = gvalid_q;
  assign grant_warpID_o = gid_q;
  assign drain_done_o   = done_q;
  assign outstanding_o  = out_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_grant_q, perf_grant_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Grant count and stall count (some request pending but nothing picked); both wrap.
  always_comb begin
    perf_grant_d = perf_grant_q + {31'd0, pick_valid};
    perf_stall_d = perf_stall_q + {31'd0, (|req_valid_i) && !pick_valid};
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_grant_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_grant_q <= perf_grant_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_grant_cnt_o = perf_grant_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_issue_arbiter.sv
// Scoreboard bench for mem_issue_arbiter: directed stimulus pushes expected
// grants (warp, cycle); a negedge monitor pops and compares every grant.
module tb_mem_issue_arbiter;

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       qa[$];
  exp_t       qb[$];

  // DUT A: default parameters
  logic [7:0] req_a = '0, g_a, blk_a;
  logic       gv_a, done_a;
  logic [2:0] gid_a;
  logic [3:0] out_a;
  logic       neg_a = 1'b0, pos_a = 1'b0, drain_a = 1'b0;
  logic [2:0] negw_a = '0, posw_a = '0;

  // DUT B: MAX_OUTSTANDING = 2
  logic [7:0] req_b = '0, g_b, blk_b;
  logic       gv_b, done_b;
  logic [2:0] gid_b;
  logic [3:0] out_b;
  logic       pos_b = 1'b0;
  logic [2:0] posw_b = '0;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] pg_a, ps_a, pg_b, ps_b;
`endif

  mem_issue_arbiter dut_a (
    .clk(clk), .rst(rst), .req_valid_i(req_a), .grant_o(g_a),
    .grant_valid_o(gv_a), .grant_warpID_o(gid_a),
    .neg_fb_valid_i(neg_a), .neg_fb_warpID_i(negw_a),
    .pos_fb_valid_i(pos_a), .pos_fb_warpID_i(posw_a),
    .drain_req_i(drain_a), .drain_done_o(done_a),
    .outstanding_o(out_a), .blocked_o(blk_a)
`ifdef MEM_ARB_PERF_EN
    , .perf_grant_cnt_o(pg_a), .perf_stall_cnt_o(ps_a)
`endif
  );

  mem_issue_arbiter #(.MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid_i(req_b), .grant_o(g_b),
    .grant_valid_o(gv_b), .grant_warpID_o(gid_b),
    .neg_fb_valid_i(1'b0), .neg_fb_warpID_i(3'd0),
    .pos_fb_valid_i(pos_b), .pos_fb_warpID_i(posw_b),
    .drain_req_i(1'b0), .drain_done_o(done_b),
    .outstanding_o(out_b), .blocked_o(blk_b)
`ifdef MEM_ARB_PERF_EN
    , .perf_grant_cnt_o(pg_b), .perf_stall_cnt_o(ps_b)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: every presented grant must match the head of its scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (gv_a === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL grant_a_unexpected: got warp %0d expected none (cycle %0d)", gid_a, cyc);
      end else begin
        e = qa.pop_front();
        chk("grant_a_warp", int'(gid_a), e.id);
        chk("grant_a_cycle", cyc, e.cyc);
        chk("grant_a_onehot", int'(g_a), 1 << e.id);
      end
    end
    if (gv_b === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL grant_b_unexpected: got warp %0d expected none (cycle %0d)", gid_b, cyc);
      end else begin
        e = qb.pop_front();
        chk("grant_b_warp", int'(gid_b), e.id);
        chk("grant_b_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push_a(input int id, input int c);
    exp_t e;
    e.id = id; e.cyc = c;
    qa.push_back(e);
  endtask

  task automatic push_b(input int id, input int c);
    exp_t e;
    e.id = id; e.cyc = c;
    qb.push_back(e);
  endtask

  // One clock: feedback pulses end, requesters drop the warp they see granted.
  task automatic step();
    @(posedge clk);
    #1;
    pos_a = 1'b0; neg_a = 1'b0; pos_b = 1'b0;
    req_a = req_a & ~g_a;
    req_b = req_b & ~g_b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    int pulses;
    int bcnt;

    // Reset state
    #12;
    chk("rst_grant_valid", int'(gv_a), 0);
    chk("rst_grant", int'(g_a), 0);
    chk("rst_outstanding", int'(out_a), 0);
    chk("rst_blocked", int'(blk_a), 0);
    chk("rst_drain_done", int'(done_a), 0);
    chk("rst_b_grant_valid", int'(gv_b), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // MAX_OUTSTANDING=2: two grants, stall, one completion frees one slot
    req_b = 8'h07; c = cyc;
    push_b(0, c + 1); push_b(1, c + 2);
    repeat (4) step();
    chk("b_outstanding_full", int'(out_b), 2);
    pos_b = 1'b1; posw_b = 3'd0; c = cyc;
    push_b(2, c + 2);
    repeat (3) step();
    chk("b_outstanding_after", int'(out_b), 2);

    // All warps request: warps 0..7 on consecutive cycles
    req_a = 8'hFF; c = cyc;
    for (int i = 0; i < 8; i++) push_a(i, c + 1 + i);
    repeat (9) step();
    chk("rr_outstanding_8", int'(out_a), 8);

    // Limit reached: no grant until one completion
    req_a = 8'h01;
    repeat (3) step();
    chk("limit_hold", int'(out_a), 8);
    pos_a = 1'b1; posw_a = 3'd1; c = cyc;
    push_a(0, c + 2);
    repeat (3) step();
    chk("limit_refill", int'(out_a), 8);

    // Bring count down to 1
    repeat (7) begin pos_a = 1'b1; step(); end
    chk("drain_pre", int'(out_a), 1);

    // Drain request together with a request: grant in transition cycle counts
    drain_a = 1'b1; req_a = 8'h10; c = cyc;
    push_a(4, c + 1);
    step();
    chk("drain_transition_count", int'(out_a), 2);
    req_a = 8'hEF; pulses = 0;
    repeat (3) begin step(); pulses += int'(done_a); end
    chk("drain_no_grant_count", int'(out_a), 2);
    repeat (2) begin pos_a = 1'b1; step(); pulses += int'(done_a); end
    chk("drain_emptied", int'(out_a), 0);
    repeat (6) begin step(); pulses += int'(done_a); end
    chk("drain_done_pulses", pulses, 1);
    drain_a = 1'b0; req_a = 8'h20; c = cyc;
    push_a(5, c + 2);
    repeat (3) step();
    chk("resume_outstanding", int'(out_a), 1);

    // Grant + pos + neg same cycle from outstanding 3
    req_a = 8'h03; c = cyc;
    push_a(0, c + 1); push_a(1, c + 2);
    repeat (3) step();
    chk("pre_triple_outstanding", int'(out_a), 3);
    req_a = 8'h04; pos_a = 1'b1; posw_a = 3'd0; neg_a = 1'b1; negw_a = 3'd1; c = cyc;
    push_a(2, c + 1);
    step();
    chk("triple_outstanding", int'(out_a), 2);
    chk("triple_blocked1", int'(blk_a[1]), 1);

    // Back-off of warp 3: blocked for 16 cycles, granted right after
    neg_a = 1'b1; negw_a = 3'd3; c = cyc;
    step();
    bcnt = int'(blk_a[3]);
    push_a(3, c + 18);
    req_a = 8'h08;
    repeat (16) begin step(); bcnt += int'(blk_a[3]); end
    chk("backoff_cycles", bcnt, 16);
    chk("backoff_cleared", int'(blk_a[3]), 0);
    repeat (2) step();
    chk("backoff_outstanding", int'(out_a), 2);

    // Re-miss while blocked reloads rather than accumulates
    neg_a = 1'b1; negw_a = 3'd5;
    step();
    bcnt = int'(blk_a[5]);
    repeat (4) begin step(); bcnt += int'(blk_a[5]); end
    neg_a = 1'b1; negw_a = 3'd5;
    repeat (20) begin step(); bcnt += int'(blk_a[5]); end
    chk("reload_cycles", bcnt, 21);
    chk("reload_outstanding", int'(out_a), 0);

    // Spurious completion saturates at zero
    pos_a = 1'b1; posw_a = 3'd2;
    step();
    chk("underflow_sat", int'(out_a), 0);

    // Same-warp pos+neg: both decrement, back-off loads
    req_a = 8'h03; c = cyc;
    push_a(0, c + 1); push_a(1, c + 2);
    repeat (3) step();
    chk("pre_same_outstanding", int'(out_a), 2);
    pos_a = 1'b1; posw_a = 3'd6; neg_a = 1'b1; negw_a = 3'd6;
    step();
    chk("same_outstanding", int'(out_a), 0);
    chk("same_blocked6", int'(blk_a[6]), 1);

    // Five in flight, pointer continues from warp 2
    req_a = 8'h1F; c = cyc;
    push_a(2, c + 1); push_a(3, c + 2); push_a(4, c + 3);
    push_a(0, c + 4); push_a(1, c + 5);
    repeat (6) step();
    chk("pre_reset_outstanding", int'(out_a), 5);
    chk("pre_reset_blocked6", int'(blk_a[6]), 1);

    // Asynchronous reset mid-cycle clears everything at once
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_outstanding", int'(out_a), 0);
    chk("async_blocked", int'(blk_a), 0);
    chk("async_grant_valid", int'(gv_a), 0);
    chk("async_grant_id", int'(gid_a), 0);
    chk("async_b_outstanding", int'(out_b), 0);
    @(posedge clk); #1;
    rst = 1'b1; req_a = 8'h40; c = cyc;
    push_a(6, c + 1);
    repeat (2) step();
    chk("post_reset_outstanding", int'(out_a), 1);
    chk("post_reset_blocked", int'(blk_a), 0);

    repeat (2) step();
    chk("scoreboard_a_empty", qa.size(), 0);
    chk("scoreboard_b_empty", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
